// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, filter length, default timing,
// host command bytes and device reply codes.
package ps2_pkg;

    localparam int unsigned FILTER_LEN         = 8;
    localparam int unsigned DEF_INHIBIT_CYCLES = 2500;
    localparam int unsigned DEF_START_TIMEOUT  = 375000;
    localparam int unsigned DEF_XFER_TIMEOUT   = 50000;
    localparam int unsigned FRAME_W            = 10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK         = 8'hFA;
    localparam logic [7:0] RESEND      = 8'hFE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_WAIT_FIRST,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_tx_state_e;

    // Bits presented on device falls 1..10: d0..d7, odd parity, stop.
    function automatic logic [FRAME_W-1:0] tx_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Debounce for one PS/2 line: the filtered value only changes after FILTER_LEN
// identical samples; fall_c flags a 1->0 transition of the filtered value.
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk25,
    input  logic clr,
    input  logic raw,
    output logic filt,
    output logic fall_c
);

    logic [FILTER_LEN-1:0] sh_q, sh_d;
    logic                  filt_q, filt_d;
    logic                  prev_q;

    always_comb begin
        sh_d   = {sh_q[FILTER_LEN-2:0], raw};
        filt_d = filt_q;
        if (&sh_q) begin
            filt_d = 1'b1;
        end else if (~|sh_q) begin
            filt_d = 1'b0;
        end
    end

    // Idle PS/2 lines are pulled high, so everything presets to 1.
    always_ff @(posedge clk25) begin
        if (clr) begin
            sh_q   <= '1;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sh_q   <= sh_d;
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    assign filt   = filt_q;
    assign fall_c = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// device-clocked shifting of data/parity/stop and acknowledge check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int unsigned XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam int unsigned CNT_W = $clog2(INHIBIT_CYCLES + START_TIMEOUT + XFER_TIMEOUT + 1);

    ps2_tx_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ps2c_oe_q, ps2c_oe_d;
    logic               ps2d_oe_q, ps2d_oe_d;
    logic               tx_busy_q, tx_busy_d;
    logic               tx_done_q, tx_done_d;
    logic               tx_err_q, tx_err_d;

    logic c_filt, c_fall_c;
    logic d_filt, unused_d_fall_c;

    ps2_line_filter u_clk_filt (
        .clk25  (clk25),
        .clr    (clr),
        .raw    (PS2C),
        .filt   (c_filt),
        .fall_c (c_fall_c)
    );

    ps2_line_filter u_dat_filt (
        .clk25  (clk25),
        .clr    (clr),
        .raw    (PS2D),
        .filt   (d_filt),
        .fall_c (unused_d_fall_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        ps2c_oe_d = ps2c_oe_q;
        ps2d_oe_d = ps2d_oe_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    frame_d   = tx_frame(tx_data);
                    bitcnt_d  = 4'd0;
                    cnt_d     = '0;
                    ps2c_oe_d = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    ps2d_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RTS: begin
                ps2c_oe_d = 1'b0;
                state_d   = ST_WAIT_FIRST;
            end
            ST_WAIT_FIRST: begin
                // The first device fall already shifts out d0.
                if (c_fall_c) begin
                    ps2d_oe_d = ~frame_q[0];
                    bitcnt_d  = 4'd1;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (c_fall_c) begin
                    ps2d_oe_d = ~frame_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (c_fall_c) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    state_d  = d_filt ? ST_ERR : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (c_filt && d_filt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One budget covers the whole device-clocked part of the transfer.
        if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
            if (cnt_q == CNT_W'(XFER_TIMEOUT - 1)) begin
                state_d = ST_ERR;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERR) begin
            ps2c_oe_d = 1'b0;
            ps2d_oe_d = 1'b0;
        end

        tx_busy_d = (state_d != ST_IDLE);
        tx_done_d = (state_d == ST_DONE);
        tx_err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk25) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= 4'd0;
            frame_q   <= '0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            frame_q   <= frame_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
            tx_err_q  <= tx_err_d;
        end
    end

    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;
    assign tx_err  = tx_err_q;
    assign ps2c_oe = ps2c_oe_q;
    assign ps2d_oe = ps2d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard clocks frames out of the
// host; received bits and outcomes are compared with a byte-level frame model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH   = 2500;
    localparam int unsigned ST_TO = 3000;
    localparam int unsigned XF_TO = 30000;

    logic       clk25 = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err;
    logic       PS2C, PS2D;
    logic       ps2c_oe, ps2d_oe;

    logic dev_clk  = 1'b1;
    logic dev_dlow = 1'b0;
    logic glitch   = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int mon_bad = 0;
    logic done_prev = 1'b0;
    logic err_prev = 1'b0;

    assign PS2C = ~ps2c_oe & dev_clk & ~glitch;
    assign PS2D = ~ps2d_oe & ~dev_dlow;

    always #20 clk25 = ~clk25;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST_TO),
        .XFER_TIMEOUT   (XF_TO)
    ) dut (
        .clk25    (clk25),
        .clr      (clr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .PS2C     (PS2C),
        .PS2D     (PS2D),
        .ps2c_oe  (ps2c_oe),
        .ps2d_oe  (ps2d_oe)
    );

    // Pulse counting plus protocol invariants between the directed steps.
    always @(negedge clk25) begin
        if (tx_done && !done_prev) done_cnt++;
        if (tx_err && !err_prev) err_cnt++;
        if ((tx_done && done_prev) || (tx_err && err_prev)) mon_bad++;
        if ((tx_done || tx_err) && !tx_busy) mon_bad++;
        if ((done_prev || err_prev) && tx_busy) mon_bad++;
        if (!tx_busy && (ps2c_oe || ps2d_oe)) mon_bad++;
        done_prev = tx_done;
        err_prev  = tx_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line levels the device sees: start 0, d0..d7, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        int par;
        for (int i = 0; i < 8; i++) ones += (int'(b) >> i) % 2;
        par = (ones % 2 == 0) ? 1 : 0;
        return 11'(int'(b) * 2 + par * 512 + 1024);
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk25);
        chk("idle_before_start", 32'(tx_busy), 32'd0);
        tx_data  = b;
        tx_start = 1'b1;
        @(posedge clk25);
        #1;
        tx_start = 1'b0;
        chk("busy_after_accept", 32'(tx_busy), 32'd1);
    endtask

    // Keyboard model: measures the inhibit, then generates nfalls clock pulses,
    // sampling the data line at the end of each low phase.
    task automatic dev_run(input int half, input int nfalls, input bit do_ack,
                           input bit do_glitch, output int inh_len, output logic [10:0] got);
        int n = 0;
        got     = '0;
        inh_len = 0;
        @(negedge clk25);
        while (!ps2c_oe && n < 10000) begin n++; @(negedge clk25); end
        while (ps2c_oe && inh_len < 10000) begin inh_len++; @(negedge clk25); end
        got[0] = PS2D;
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && do_ack) begin
                repeat (half / 2) @(negedge clk25);
                dev_dlow = 1'b1;
                repeat (half - half / 2) @(negedge clk25);
            end else if (k == 4 && do_glitch) begin
                repeat (half / 2) @(negedge clk25);
                glitch = 1'b1;
                repeat (3) @(negedge clk25);
                glitch = 1'b0;
                repeat (half - half / 2 - 3) @(negedge clk25);
            end else begin
                repeat (half) @(negedge clk25);
            end
            dev_clk = 1'b0;
            repeat (half) @(negedge clk25);
            if (k <= 10) got[k] = PS2D;
            dev_clk = 1'b1;
            if (k == 11) dev_dlow = 1'b0;
        end
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] b, input int half,
                            input bit do_ack, input bit do_glitch, input bit poke);
        int inh;
        int n = 0;
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [10:0] got;
        send(b);
        fork
            dev_run(half, 11, do_ack, do_glitch, inh, got);
            if (poke) begin
                repeat (40) @(negedge clk25);
                tx_data  = ~b;
                tx_start = 1'b1;
                @(posedge clk25);
                #1;
                tx_start = 1'b0;
            end
        join
        while (done_cnt == d0 && err_cnt == e0 && n < 5000) begin
            @(negedge clk25);
            n++;
        end
        repeat (3) @(negedge clk25);
        chk({tag, "_inhibit_len"}, 32'(inh), 32'(INH + 1));
        chk({tag, "_frame"}, 32'(got), 32'(exp_frame(b)));
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), do_ack ? 32'd1 : 32'd0);
        chk({tag, "_err_pulses"}, 32'(err_cnt - e0), do_ack ? 32'd0 : 32'd1);
        chk({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        int inh;
        int n;
        int d0;
        int e0;
        logic [10:0] got;

        // Reset state
        repeat (3) @(posedge clk25);
        #1;
        chk("reset_outputs", 32'({tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe}), 32'd0);
        @(negedge clk25);
        clr = 1'b0;
        repeat (5) @(negedge clk25);

        // Set-LED command at 12.5 kHz device clock, acknowledged
        run_xfer("set_led", CMD_SET_LED, 1000, 1'b1, 1'b0, 1'b0);

        // All-ones byte: parity 1, data line released for every bit
        run_xfer("reset_cmd", CMD_RESET, 100, 1'b1, 1'b0, 1'b0);

        // Device never clocks: error START_TIMEOUT cycles after release
        e0 = err_cnt;
        send(8'h5A);
        dev_run(100, 0, 1'b0, 1'b0, inh, got);
        chk("timeout_inhibit_len", 32'(inh), 32'(INH + 1));
        chk("timeout_start_bit", 32'(got[0]), 32'd0);
        n = 0;
        while (!tx_err && n < int'(ST_TO) + 100) begin
            @(posedge clk25);
            #1;
            n++;
        end
        chk("start_timeout_latency", 32'(n), 32'(ST_TO));
        chk("timeout_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        repeat (3) @(negedge clk25);
        chk("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);

        // Missing acknowledge
        run_xfer("no_ack", 8'h3C, 100, 1'b0, 1'b0, 1'b0);

        // clr after the fourth device fall aborts silently
        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_SET_LED);
        dev_run(100, 4, 1'b0, 1'b0, inh, got);
        chk("abort_busy_before_clr", 32'(tx_busy), 32'd1);
        @(negedge clk25);
        clr = 1'b1;
        @(posedge clk25);
        #1;
        chk("abort_outputs_after_clr", 32'({tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe}), 32'd0);
        @(negedge clk25);
        clr = 1'b0;
        repeat (50) @(negedge clk25);
        chk("abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        run_xfer("enable_after_clr", CMD_ENABLE, 100, 1'b1, 1'b0, 1'b0);

        // Second request while busy is dropped; short clock glitch is filtered
        run_xfer("busy_glitch", 8'hA7, 100, 1'b1, 1'b1, 1'b1);
        d0 = done_cnt;
        n = 0;
        repeat (200) begin
            @(negedge clk25);
            if (tx_busy || ps2c_oe) n++;
        end
        chk("busy_request_ignored", 32'(n), 32'd0);
        chk("busy_no_extra_done", 32'(done_cnt - d0), 32'd0);

        // Random bytes at random device clock rates
        for (int r = 0; r < 3; r++) begin
            run_xfer("random", 8'($urandom), int'($urandom_range(150, 60)), 1'b1, 1'b0, 1'b0);
        end

        chk("monitor_invariants", 32'(mon_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter that sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It shares the open-collector PS2C/PS2D lines with the existing scan-code receiver and runs the full request-to-send sequence, device-clocked bit shifting, parity and acknowledge check. Top level gates the receiver with tx_busy so that the receiver does not decode the outgoing frame.

Parameters:
INHIBIT_CYCLES, 2500, clock-inhibit hold time in clk25 cycles (100 us at 25 MHz)
START_TIMEOUT, 375000, max cycles from clock release to first device falling edge (15 ms)
XFER_TIMEOUT, 50000, max cycles from first device falling edge to ack (2 ms)
FILTER_LEN, 8, samples a line must hold stable before the filtered value changes

Ports:
clk25  in  1  system clock, 25 MHz
clr  in  1  reset, synchronous, active-high
tx_data  in  8  command byte, sampled when tx_start is accepted
tx_start  in  1  single-cycle request; ignored while tx_busy=1
tx_busy  out  1  high from acceptance until done/error pulse (inclusive)
tx_done  out  1  one-cycle pulse: device acked (data low on 11th clock)
tx_err  out  1  one-cycle pulse: timeout or missing ack
PS2C  in  1  raw clock line
PS2D  in  1  raw data line
ps2c_oe  out  1  1 = drive PS2C low, 0 = release (pad tristates)
ps2d_oe  out  1  1 = drive PS2D low, 0 = release

Behaviour:
- One clock, clk25. clr is synchronous, active-high, honoured in any state: next edge -> IDLE, all outputs 0, lines released, counters cleared, filters preset to 1.
- Filter: each line is shifted into a FILTER_LEN register. Filtered value goes 1 when all bits are 1 and 0 when all bits are 0; otherwise it holds. fall_c = filtered clock was 1 last cycle and is 0 now.
- Parity: odd; par = ~^tx_data, latched at acceptance with the byte.
- States:
  - IDLE: tx_busy=0. When tx_start=1: latch byte/parity, bitcnt=0, -> INHIBIT.
  - INHIBIT: ps2c_oe=1, count INHIBIT_CYCLES, then ps2d_oe=1 (start bit) -> RTS.
  - RTS: hold ps2d_oe=1 and ps2c_oe=1 for 1 more cycle, then ps2c_oe=0 -> WAIT_FIRST. ps2d_oe stays 1 from here until bit 0 is presented.
  - WAIT_FIRST: on fall_c -> SHIFT (this edge is handled as in SHIFT). After START_TIMEOUT cycles with no fall_c -> ERR.
  - SHIFT: on each fall_c present the next bit: falls 1-8 d0..d7 LSB first, fall 9 parity, fall 10 stop (ps2d_oe=0). Drive rule: ps2d_oe = ~bit. bitcnt increments per fall_c. After fall 10 -> ACK.
  - ACK: on fall_c 11, sample filtered data: 0 -> WAIT_IDLE, 1 -> ERR.
  - WAIT_IDLE: both filtered lines 1 -> DONE.
  - DONE: tx_done=1 for one cycle -> IDLE.
  - ERR: tx_err=1 for one cycle, both oe=0 -> IDLE.
- XFER_TIMEOUT counter starts at the first fall_c and covers SHIFT, ACK and WAIT_IDLE. Expiry -> ERR.
- Latency: tx_busy rises the cycle after tx_start is accepted. The clock is inhibited for exactly INHIBIT_CYCLES+1 cycles. tx_done/tx_err falls in the same cycle that tx_busy falls.
- Simultaneous events: a tx_start in the DONE/ERR cycle is ignored. clr wins over every event.
- The block never drives a line high. While tx_busy=0, ps2c_oe and ps2d_oe are always 0.

Decomposition:
- Shared package ps2_pkg holds: state enum; FILTER_LEN and default timing constants; command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4; device reply constants ACK=8'hFA, RESEND=8'hFE.
- One sub-module, ps2_line_filter (FILTER_LEN debounce plus falling-edge output), instantiated twice (clock, data). The receiver can reuse it.

Test Plan:
- tx_data=8'hED, device model clocks 11 falls at 12.5 kHz and acks -> PS2C held low for 2501 cycles; sampled bits 0,1,0,1,1,0,1,1,1 then stop=1 (d0..d7 LSB first, parity=1); tx_done one pulse; tx_busy low afterwards.
- tx_data=8'hFF -> parity bit 1 is wrong case check: all data 1, parity=1 (eight ones, odd parity); ps2d_oe=0 during bits 1-10; tx_done.
- Device never clocks -> tx_err exactly START_TIMEOUT cycles after clock release; both oe=0.
- Device clocks 11 times but leaves PS2D high at fall 11 -> tx_err, no tx_done.
- clr asserted mid-SHIFT (after fall 4) -> next cycle IDLE, oe=0, tx_busy=0, no pulse; a new 8'hF4 transfer then completes normally.
- tx_start pulsed while busy, and 3-cycle glitches on PS2C during SHIFT -> second request ignored, glitches produce no extra bit (falls counted 11 exactly).
